if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It is the upstream end of the fetch/decode interface:
- produces {inst, pc} to decode;
- consumes the branch bus from decode;
- drives the synchronous instruction SRAM.

---
 rtl/if_stage.sv | 150 +++++++++++++++
 tb/tb_if_stage.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : MIPS 5-stage pipeline instruction fetch. Contains the pre-IF
//            next-PC logic, the IF register, a branch-pending latch and a
//            one-entry instruction buffer for decode back-pressure.
// Options  : IF_PERF_CNT_EN adds the fetch_cnt IF-to-decode transfer counter.
// Revision : 1.0
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC        = 32'hbfc00000,
  parameter int          FS_TO_DS_BUS_WD = 64,
  parameter int          BR_BUS_WD       = 34
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_wen,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]                fetch_cnt
`endif
);

  localparam logic [31:0] c_PC_RESET = RESET_PC - 32'd4;

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        br_pending_q, br_pending_d;
  logic [31:0] br_pending_target_q, br_pending_target_d;
  logic        req_out_q, req_out_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_q, buf_d;

  logic        w_br_stall;
  logic        w_br_taken;
  logic [31:0] w_br_target;
  logic [31:0] w_seq_pc;
  logic        w_redirect;
  logic [31:0] w_nextpc;
  logic        w_to_fs_valid;
  logic        w_fs_ready_go;
  logic        w_fs_allowin;
  logic        w_xfer;
  logic        w_buf_capture;
  logic [31:0] w_inst;

  assign w_br_stall  = br_bus[33];
  assign w_br_taken  = br_bus[32];
  assign w_br_target = br_bus[31:0];

  // A taken branch only redirects once its delay slot is already in IF.
  assign w_seq_pc      = fs_pc_q + 32'd4;
  assign w_redirect    = w_br_taken & ~w_br_stall & fs_valid_q;
  assign w_nextpc      = br_pending_q ? br_pending_target_q :
                         w_redirect   ? w_br_target         : w_seq_pc;
  assign w_to_fs_valid = ~reset & ~w_br_stall;

  assign w_fs_ready_go = 1'b1;
  assign w_fs_allowin  = ~fs_valid_q | (w_fs_ready_go & ds_allowin);

  assign inst_sram_en    = w_to_fs_valid & w_fs_allowin;
  assign inst_sram_addr  = w_nextpc;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_wdata = 32'h0;

  assign fs_to_ds_valid = fs_valid_q & w_fs_ready_go;
  assign w_xfer         = fs_to_ds_valid & ds_allowin;

  // Hold the returned word if decode refuses it in the response cycle.
  assign w_buf_capture = req_out_q & fs_valid_q & ~ds_allowin & ~buf_valid_q;

  assign w_inst       = buf_valid_q ? buf_q :
                        fs_valid_q  ? inst_sram_rdata : 32'h0;
  assign fs_to_ds_bus = {w_inst, fs_pc_q};

  always_comb begin
    fs_valid_d          = fs_valid_q;
    fs_pc_d             = fs_pc_q;
    br_pending_d        = br_pending_q;
    br_pending_target_d = br_pending_target_q;
    req_out_d           = inst_sram_en;
    buf_valid_d         = buf_valid_q;
    buf_d               = buf_q;

    if (w_fs_allowin) begin
      fs_valid_d = w_to_fs_valid;
    end
    if (inst_sram_en) begin
      fs_pc_d = w_nextpc;
    end

    if (br_pending_q && inst_sram_en) begin
      br_pending_d = 1'b0;
    end else if (w_redirect && !inst_sram_en) begin
      br_pending_d        = 1'b1;
      br_pending_target_d = w_br_target;
    end

    if (w_xfer) begin
      buf_valid_d = 1'b0;
    end else if (w_buf_capture) begin
      buf_valid_d = 1'b1;
      buf_d       = inst_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid_q          <= 1'b0;
      fs_pc_q             <= c_PC_RESET;
      br_pending_q        <= 1'b0;
      br_pending_target_q <= 32'h0;
      req_out_q           <= 1'b0;
      buf_valid_q         <= 1'b0;
      buf_q               <= 32'h0;
    end else begin
      fs_valid_q          <= fs_valid_d;
      fs_pc_q             <= fs_pc_d;
      br_pending_q        <= br_pending_d;
      br_pending_target_q <= br_pending_target_d;
      req_out_q           <= req_out_d;
      buf_valid_q         <= buf_valid_d;
      buf_q               <= buf_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_q <= 32'h0;
    end else if (w_xfer) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Self-checking bench for if_stage: request/transfer scoreboards
//            fed by each scenario task, plus inline cycle checks.
// Revision : 1.0
// ============================================================================
module tb_if_stage;

  localparam logic [33:0] c_STALL = 34'h2_0000_0000;

  logic        clk;
  logic        reset;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic [33:0] br_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int nchk;
  int nerr;

  logic [31:0] exp_addr[$];
  logic [63:0] exp_xfer[$];

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .br_bus          (br_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt       (fetch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5a5aa5a5;
  endfunction

  // Synchronous SRAM: addressed word the cycle after a request, noise otherwise.
  logic        sram_req;
  logic [31:0] sram_a;
  initial begin
    sram_req = 1'b0;
    sram_a   = 32'h0;
    inst_sram_rdata = 32'h0;
  end
  always @(negedge clk) begin
    sram_req = inst_sram_en;
    sram_a   = inst_sram_addr;
  end
  always @(posedge clk) begin
    inst_sram_rdata <= sram_req ? word_of(sram_a) : $urandom;
  end

  // Scoreboard consumer: every request and every decode transfer pops in order.
  always @(negedge clk) begin
    logic [31:0] ea;
    logic [63:0] ex;
    if (!reset) begin
      if (inst_sram_en) begin
        nchk++;
        if (exp_addr.size() == 0) begin
          nerr++;
          $display("FAIL req_addr: got request to %h, required no request", inst_sram_addr);
        end else begin
          ea = exp_addr.pop_front();
          if (inst_sram_addr !== ea) begin
            nerr++;
            $display("FAIL req_addr: got %h, required %h", inst_sram_addr, ea);
          end
        end
      end
      if (fs_to_ds_valid && ds_allowin) begin
        nchk++;
        if (exp_xfer.size() == 0) begin
          nerr++;
          $display("FAIL xfer: got transfer %h, required no transfer", fs_to_ds_bus);
        end else begin
          ex = exp_xfer.pop_front();
          if (fs_to_ds_bus !== ex) begin
            nerr++;
            $display("FAIL xfer: got %h, required %h", fs_to_ds_bus, ex);
          end
        end
      end
    end
  end

  task automatic push_fetch(input logic [31:0] pc);
    exp_addr.push_back(pc);
    exp_xfer.push_back({word_of(pc), pc});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step after reset release, in the first fetch cycle.
  task automatic do_reset();
    tick();
    reset      = 1'b1;
    ds_allowin = 1'b1;
    br_bus     = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    br_bus     = c_STALL;
    ds_allowin = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    nchk++;
    if (fs_to_ds_valid !== 1'b0) begin
      nerr++; $display("FAIL reset_valid: got %b, required 0", fs_to_ds_valid);
    end
    nchk++;
    if (inst_sram_en !== 1'b0) begin
      nerr++; $display("FAIL reset_en: got %b, required 0", inst_sram_en);
    end
    nchk++;
    if (fs_to_ds_bus !== {32'h0, 32'hbfbffffc}) begin
      nerr++; $display("FAIL reset_bus: got %h, required %h", fs_to_ds_bus, {32'h0, 32'hbfbffffc});
    end
    nchk++;
    if (inst_sram_wen !== 4'h0 || inst_sram_wdata !== 32'h0) begin
      nerr++; $display("FAIL reset_wr: got wen %h wdata %h, required 0 and 0", inst_sram_wen, inst_sram_wdata);
    end
`ifdef IF_PERF_CNT_EN
    nchk++;
    if (fetch_cnt !== 32'h0) begin
      nerr++; $display("FAIL reset_cnt: got %0d, required 0", fetch_cnt);
    end
`endif
  endtask

  task automatic test_sequential();
    do_reset();
    push_fetch(32'hbfc00000);
    push_fetch(32'hbfc00004);
    push_fetch(32'hbfc00008);
    @(negedge clk);
    nchk++;
    if (inst_sram_addr !== 32'hbfc00000 || inst_sram_en !== 1'b1) begin
      nerr++; $display("FAIL first_req: got en %b addr %h, required 1 bfc00000", inst_sram_en, inst_sram_addr);
    end
    tick();
    @(negedge clk);
    nchk++;
    if (fs_to_ds_bus[31:0] !== 32'hbfc00000 || fs_to_ds_valid !== 1'b1) begin
      nerr++; $display("FAIL first_pc: got valid %b pc %h, required 1 bfc00000", fs_to_ds_valid, fs_to_ds_bus[31:0]);
    end
    tick();
    tick();
    drain();
    nchk++;
    if (exp_addr.size() != 0 || exp_xfer.size() != 0) begin
      nerr++; $display("FAIL seq_left: got %0d/%0d pending, required 0/0", exp_addr.size(), exp_xfer.size());
    end
`ifdef IF_PERF_CNT_EN
    nchk++;
    if (fetch_cnt !== 32'd3) begin
      nerr++; $display("FAIL seq_cnt: got %0d, required 3", fetch_cnt);
    end
`endif
  endtask

  task automatic test_backpressure();
    do_reset();
    push_fetch(32'hbfc00000);
    push_fetch(32'hbfc00004);
    push_fetch(32'hbfc00008);
    tick();
    tick();
    ds_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nchk++;
      if (inst_sram_en !== 1'b0) begin
        nerr++; $display("FAIL bp_en[%0d]: got %b, required 0", i, inst_sram_en);
      end
      nchk++;
      if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {word_of(32'hbfc00004), 32'hbfc00004}) begin
        nerr++; $display("FAIL bp_hold[%0d]: got %b %h, required 1 %h", i, fs_to_ds_valid, fs_to_ds_bus, {word_of(32'hbfc00004), 32'hbfc00004});
      end
      tick();
    end
    ds_allowin = 1'b1;
    tick();
    drain();
    nchk++;
    if (exp_addr.size() != 0 || exp_xfer.size() != 0) begin
      nerr++; $display("FAIL bp_left: got %0d/%0d pending, required 0/0", exp_addr.size(), exp_xfer.size());
    end
  endtask

  task automatic test_redirect();
    do_reset();
    push_fetch(32'hbfc00000);
    push_fetch(32'hbfc00004);
    push_fetch(32'hbfc00008);
    push_fetch(32'hbfc00100);
    push_fetch(32'hbfc00104);
    tick();
    tick();
    tick();
    br_bus = {1'b0, 1'b1, 32'hbfc00100};
    @(negedge clk);
    nchk++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc00100) begin
      nerr++; $display("FAIL redir_addr: got en %b addr %h, required 1 bfc00100", inst_sram_en, inst_sram_addr);
    end
    tick();
    br_bus = '0;
    tick();
    drain();
    nchk++;
    if (exp_addr.size() != 0 || exp_xfer.size() != 0) begin
      nerr++; $display("FAIL redir_left: got %0d/%0d pending, required 0/0", exp_addr.size(), exp_xfer.size());
    end
  endtask

  task automatic test_stall_branch();
    do_reset();
    push_fetch(32'hbfc00000);
    push_fetch(32'hbfc00004);
    push_fetch(32'hbfc00200);
    tick();
    tick();
    br_bus     = c_STALL;
    ds_allowin = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nchk++;
      if (inst_sram_en !== 1'b0) begin
        nerr++; $display("FAIL stall_en[%0d]: got %b, required 0", i, inst_sram_en);
      end
      tick();
    end
    br_bus     = {1'b0, 1'b1, 32'hbfc00200};
    ds_allowin = 1'b1;
    @(negedge clk);
    nchk++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc00200) begin
      nerr++; $display("FAIL stall_tgt: got en %b addr %h, required 1 bfc00200", inst_sram_en, inst_sram_addr);
    end
    tick();
    drain();
    nchk++;
    if (exp_addr.size() != 0 || exp_xfer.size() != 0) begin
      nerr++; $display("FAIL stall_left: got %0d/%0d pending, required 0/0", exp_addr.size(), exp_xfer.size());
    end
  endtask

  task automatic test_pending();
    do_reset();
    push_fetch(32'hbfc00000);
    push_fetch(32'hbfc00004);
    push_fetch(32'hbfc00300);
    push_fetch(32'hbfc00304);
    tick();
    tick();
    ds_allowin = 1'b0;
    br_bus     = {1'b0, 1'b1, 32'hbfc00300};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nchk++;
      if (inst_sram_en !== 1'b0) begin
        nerr++; $display("FAIL pend_en[%0d]: got %b, required 0", i, inst_sram_en);
      end
      tick();
    end
    ds_allowin = 1'b1;
    br_bus     = '0;
    @(negedge clk);
    nchk++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc00300) begin
      nerr++; $display("FAIL pend_tgt: got en %b addr %h, required 1 bfc00300", inst_sram_en, inst_sram_addr);
    end
    tick();
    @(negedge clk);
    nchk++;
    if (inst_sram_addr !== 32'hbfc00304) begin
      nerr++; $display("FAIL pend_clear: got %h, required bfc00304", inst_sram_addr);
    end
    tick();
    drain();
    nchk++;
    if (exp_addr.size() != 0 || exp_xfer.size() != 0) begin
      nerr++; $display("FAIL pend_left: got %0d/%0d pending, required 0/0", exp_addr.size(), exp_xfer.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    push_fetch(32'hbfc00000);
    push_fetch(32'hfffffffc);
    push_fetch(32'h00000000);
    tick();
    br_bus = {1'b0, 1'b1, 32'hfffffffc};
    tick();
    br_bus = '0;
    @(negedge clk);
    nchk++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h0) begin
      nerr++; $display("FAIL wrap_addr: got en %b addr %h, required 1 00000000", inst_sram_en, inst_sram_addr);
    end
    tick();
    drain();
    nchk++;
    if (exp_addr.size() != 0 || exp_xfer.size() != 0) begin
      nerr++; $display("FAIL wrap_left: got %0d/%0d pending, required 0/0", exp_addr.size(), exp_xfer.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 61; i++) begin
      push_fetch(32'hbfc00000 + 32'(4 * i));
    end
    for (int i = 0; i < 40; i++) begin
      ds_allowin = 1'($urandom_range(0, 1));
      tick();
    end
    drain();
    nchk++;
    if (exp_addr.size() != exp_xfer.size() || exp_xfer.size() >= 61) begin
      nerr++; $display("FAIL b2b_balance: got %0d requests left vs %0d transfers left, required equal and below 61", exp_addr.size(), exp_xfer.size());
    end
`ifdef IF_PERF_CNT_EN
    nchk++;
    if (fetch_cnt !== 32'(61 - exp_xfer.size())) begin
      nerr++; $display("FAIL b2b_cnt: got %0d, required %0d", fetch_cnt, 61 - exp_xfer.size());
    end
`endif
    exp_addr.delete();
    exp_xfer.delete();
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    exp_addr.push_back(32'hbfc00000);
    exp_addr.push_back(32'hbfc00004);
    exp_xfer.push_back({word_of(32'hbfc00000), 32'hbfc00000});
    tick();
    tick();
    reset = 1'b1;
    #1;
    nchk++;
    if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b0) begin
      nerr++; $display("FAIL midrst_valid: got valid %b en %b, required 0 0", fs_to_ds_valid, inst_sram_en);
    end
    nchk++;
    if (fs_to_ds_bus !== {32'h0, 32'hbfbffffc}) begin
      nerr++; $display("FAIL midrst_bus: got %h, required %h", fs_to_ds_bus, {32'h0, 32'hbfbffffc});
    end
`ifdef IF_PERF_CNT_EN
    nchk++;
    if (fetch_cnt !== 32'h0) begin
      nerr++; $display("FAIL midrst_cnt: got %0d, required 0", fetch_cnt);
    end
`endif
    tick();
    tick();
    reset = 1'b0;
    push_fetch(32'hbfc00000);
    @(negedge clk);
    nchk++;
    if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc00000) begin
      nerr++; $display("FAIL midrst_first: got en %b addr %h, required 1 bfc00000", inst_sram_en, inst_sram_addr);
    end
    tick();
    drain();
    nchk++;
    if (exp_addr.size() != 0 || exp_xfer.size() != 0) begin
      nerr++; $display("FAIL midrst_left: got %0d/%0d pending, required 0/0", exp_addr.size(), exp_xfer.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nchk       = 0;
    nerr       = 0;
    reset      = 1'b1;
    ds_allowin = 1'b1;
    br_bus     = '0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_stall_branch();
    test_pending();
    test_wrap();
    test_back_to_back();
    test_reset_midfetch();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule
`default_nettype wire
